// File: rtl/axi_id_pool_dual_free_if.sv
// Handshake bundle between the AW/AR issue path, B/R release paths and the ID pool.
interface axi_id_pool_dual_free_if #(
  parameter int ID_WIDTH = 4
);
  logic                alloc_req;
  logic                alloc_valid;
  logic [ID_WIDTH-1:0] alloc_id;
  logic                free_b_valid;
  logic [ID_WIDTH-1:0] free_b_id;
  logic                free_r_valid;
  logic [ID_WIDTH-1:0] free_r_id;
  logic [ID_WIDTH:0]   free_count;
  logic                pool_low;
  logic                err_valid;
  logic [ID_WIDTH-1:0] err_id;
  logic                err_clear;

  modport slave (
    input  alloc_req, free_b_valid, free_b_id, free_r_valid, free_r_id, err_clear,
    output alloc_valid, alloc_id, free_count, pool_low, err_valid, err_id
  );

  modport master (
    output alloc_req, free_b_valid, free_b_id, free_r_valid, free_r_id, err_clear,
    input  alloc_valid, alloc_id, free_count, pool_low, err_valid, err_id
  );
endinterface

// File: rtl/axi_id_pool_dual_free.sv
// Bitmap AXI ID allocator: lowest-index grant each cycle, two release ports (B, R),
// illegal/double-free detection with sticky first-error capture, occupancy status.
module axi_id_pool_dual_free #(
  parameter int ID_WIDTH      = 4,
  parameter int ID_COUNT      = 1 << ID_WIDTH,
  parameter int LOW_WATERMARK = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  axi_id_pool_dual_free_if.slave pool
);
  logic [ID_COUNT-1:0] free_map;
  logic [ID_COUNT-1:0] free_map_n;
  logic [ID_WIDTH:0]   free_count;
  logic [ID_WIDTH:0]   free_count_n;
  logic                err_valid;
  logic [ID_WIDTH-1:0] err_id;
  logic                err_valid_n;
  logic [ID_WIDTH-1:0] err_id_n;

  logic [ID_WIDTH-1:0] grant_id;
  logic                grant_valid;
  logic                take;
  logic                b_in_range, b_is_free, r_in_range, r_is_free;
  logic                legal_b, legal_r, illegal_b, illegal_r;

  // Lowest-index free ID; walking downward lets the lowest set bit win.
  always_comb begin
    grant_id = '0;
    for (int i = ID_COUNT - 1; i >= 0; i--) begin
      if (free_map[i]) grant_id = ID_WIDTH'(i);
    end
  end

  assign grant_valid = |free_map;
  assign take        = pool.alloc_req && grant_valid;

  // Range/state lookup by compare so IDs >= ID_COUNT never index the map.
  always_comb begin
    b_in_range = 1'b0;
    b_is_free  = 1'b0;
    r_in_range = 1'b0;
    r_is_free  = 1'b0;
    for (int i = 0; i < ID_COUNT; i++) begin
      if (pool.free_b_id == ID_WIDTH'(i)) begin
        b_in_range = 1'b1;
        b_is_free  = free_map[i];
      end
      if (pool.free_r_id == ID_WIDTH'(i)) begin
        r_in_range = 1'b1;
        r_is_free  = free_map[i];
      end
    end
  end

  // When both ports return the same ID, B owns it and R becomes a double free.
  assign legal_b   = pool.free_b_valid && b_in_range && !b_is_free;
  assign legal_r   = pool.free_r_valid && r_in_range && !r_is_free &&
                     !(legal_b && (pool.free_b_id == pool.free_r_id));
  assign illegal_b = pool.free_b_valid && !legal_b;
  assign illegal_r = pool.free_r_valid && !legal_r;

  always_comb begin
    free_map_n = free_map;
    for (int i = 0; i < ID_COUNT; i++) begin
      if (take && (grant_id == ID_WIDTH'(i)))              free_map_n[i] = 1'b0;
      if (legal_b && (pool.free_b_id == ID_WIDTH'(i)))     free_map_n[i] = 1'b1;
      if (legal_r && (pool.free_r_id == ID_WIDTH'(i)))     free_map_n[i] = 1'b1;
    end
    free_count_n = free_count - (ID_WIDTH+1)'(take)
                 + (ID_WIDTH+1)'(legal_b) + (ID_WIDTH+1)'(legal_r);
  end

  // Clear beats a same-cycle error; otherwise only the first error is kept, B before R.
  always_comb begin
    err_valid_n = err_valid;
    err_id_n    = err_id;
    if (pool.err_clear) begin
      err_valid_n = 1'b0;
      err_id_n    = '0;
    end else if (!err_valid && illegal_b) begin
      err_valid_n = 1'b1;
      err_id_n    = pool.free_b_id;
    end else if (!err_valid && illegal_r) begin
      err_valid_n = 1'b1;
      err_id_n    = pool.free_r_id;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      free_map   <= '1;
      free_count <= (ID_WIDTH+1)'(ID_COUNT);
      err_valid  <= 1'b0;
      err_id     <= '0;
    end else begin
      free_map   <= free_map_n;
      free_count <= free_count_n;
      err_valid  <= err_valid_n;
      err_id     <= err_id_n;
    end
  end

  assign pool.alloc_valid = grant_valid;
  assign pool.alloc_id    = grant_id;
  assign pool.free_count  = free_count;
  assign pool.pool_low    = int'(free_count) <= LOW_WATERMARK;
  assign pool.err_valid   = err_valid;
  assign pool.err_id      = err_id;
endmodule

// File: tb/tb_axi_id_pool_dual_free.sv
// Directed bench: full 16-ID pool (pa) and a partial 12-ID pool (pb) sharing clock and reset.
module tb_axi_id_pool_dual_free;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  axi_id_pool_dual_free_if #(.ID_WIDTH(4)) pa ();
  axi_id_pool_dual_free_if #(.ID_WIDTH(4)) pb ();

  axi_id_pool_dual_free #(.ID_WIDTH(4), .ID_COUNT(16), .LOW_WATERMARK(2)) dut_a (
    .clk(clk), .reset(reset), .pool(pa)
  );
  axi_id_pool_dual_free #(.ID_WIDTH(4), .ID_COUNT(12), .LOW_WATERMARK(2)) dut_b (
    .clk(clk), .reset(reset), .pool(pb)
  );

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    pa.alloc_req = 0; pa.free_b_valid = 0; pa.free_b_id = 0;
    pa.free_r_valid = 0; pa.free_r_id = 0; pa.err_clear = 0;
    pb.alloc_req = 0; pb.free_b_valid = 0; pb.free_b_id = 0;
    pb.free_r_valid = 0; pb.free_r_id = 0; pb.err_clear = 0;
  endtask

  task automatic free_b(input int id);
    pa.free_b_valid = 1; pa.free_b_id = 4'(id);
    cyc();
    pa.free_b_valid = 0;
  endtask

  initial begin
    idle_all();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    chk("rst_alloc_valid", int'(pa.alloc_valid), 1);
    chk("rst_alloc_id", int'(pa.alloc_id), 0);
    chk("rst_free_count", int'(pa.free_count), 16);
    chk("rst_pool_low", int'(pa.pool_low), 0);
    chk("rst_err_valid", int'(pa.err_valid), 0);
    chk("rst_err_id", int'(pa.err_id), 0);

    // Drain the pool in order
    pa.alloc_req = 1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain_id%0d", i), int'(pa.alloc_id), i);
      chk($sformatf("drain_vld%0d", i), int'(pa.alloc_valid), 1);
      cyc();
      chk($sformatf("drain_cnt%0d", i), int'(pa.free_count), 15 - i);
      chk($sformatf("drain_low%0d", i), int'(pa.pool_low), (15 - i <= 2) ? 1 : 0);
    end
    chk("empty_vld", int'(pa.alloc_valid), 0);
    chk("empty_id", int'(pa.alloc_id), 0);
    cyc();
    chk("empty_req_ignored", int'(pa.free_count), 0);
    pa.alloc_req = 0;

    // Refill from R while empty; not visible until next cycle
    pa.free_r_valid = 1; pa.free_r_id = 4'd9;
    chk("rel9_same_cycle_vld", int'(pa.alloc_valid), 0);
    cyc();
    pa.free_r_valid = 0;
    chk("rel9_vld", int'(pa.alloc_valid), 1);
    chk("rel9_id", int'(pa.alloc_id), 9);
    chk("rel9_cnt", int'(pa.free_count), 1);
    pa.alloc_req = 1;
    cyc();
    pa.alloc_req = 0;
    chk("take9_cnt", int'(pa.free_count), 0);
    chk("take9_vld", int'(pa.alloc_valid), 0);

    // Alloc 0 while B frees 5 and R frees 3
    free_b(0);
    chk("free0_cnt", int'(pa.free_count), 1);
    pa.alloc_req = 1;
    pa.free_b_valid = 1; pa.free_b_id = 4'd5;
    pa.free_r_valid = 1; pa.free_r_id = 4'd3;
    chk("mix_alloc_id", int'(pa.alloc_id), 0);
    cyc();
    idle_all();
    chk("mix_cnt", int'(pa.free_count), 2);
    chk("mix_lowest", int'(pa.alloc_id), 3);
    chk("mix_no_err", int'(pa.err_valid), 0);

    // Double free of 7, sticky first error, clear
    free_b(7);
    chk("free7_cnt", int'(pa.free_count), 3);
    free_b(7);
    chk("dbl7_err_vld", int'(pa.err_valid), 1);
    chk("dbl7_err_id", int'(pa.err_id), 7);
    chk("dbl7_cnt", int'(pa.free_count), 3);
    free_b(4);
    free_b(4);
    chk("dbl4_keeps7", int'(pa.err_id), 7);
    chk("dbl4_cnt", int'(pa.free_count), 4);
    pa.err_clear = 1;
    cyc();
    pa.err_clear = 0;
    chk("clr_err_vld", int'(pa.err_valid), 0);
    chk("clr_err_id", int'(pa.err_id), 0);

    // Clear wins over a same-cycle illegal free
    pa.err_clear = 1; pa.free_b_valid = 1; pa.free_b_id = 4'd3;
    cyc();
    idle_all();
    chk("clr_prio_vld", int'(pa.err_valid), 0);

    // Both ports illegal: B id captured
    pa.free_b_valid = 1; pa.free_b_id = 4'd3;
    pa.free_r_valid = 1; pa.free_r_id = 4'd5;
    cyc();
    idle_all();
    chk("both_ill_id", int'(pa.err_id), 3);
    pa.err_clear = 1;
    cyc();
    pa.err_clear = 0;

    // Same legal ID on both ports: freed once, R flagged
    pa.free_b_valid = 1; pa.free_b_id = 4'd6;
    pa.free_r_valid = 1; pa.free_r_id = 4'd6;
    cyc();
    idle_all();
    chk("same6_cnt", int'(pa.free_count), 5);
    chk("same6_err_vld", int'(pa.err_valid), 1);
    chk("same6_err_id", int'(pa.err_id), 6);

    // 12-ID pool: out-of-range release, bounded allocation
    chk("p12_rst_cnt", int'(pb.free_count), 12);
    pb.free_b_valid = 1; pb.free_b_id = 4'd13;
    cyc();
    pb.free_b_valid = 0;
    chk("p12_oor_vld", int'(pb.err_valid), 1);
    chk("p12_oor_id", int'(pb.err_id), 13);
    chk("p12_oor_cnt", int'(pb.free_count), 12);
    pb.alloc_req = 1;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("p12_id%0d", i), int'(pb.alloc_id), i);
      cyc();
    end
    chk("p12_empty_vld", int'(pb.alloc_valid), 0);
    chk("p12_empty_id", int'(pb.alloc_id), 0);
    chk("p12_empty_cnt", int'(pb.free_count), 0);
    pb.alloc_req = 0;
    pb.free_r_valid = 1; pb.free_r_id = 4'd2;
    cyc();
    pb.free_r_valid = 0;
    chk("p12_rel2_id", int'(pb.alloc_id), 2);

    // Mid-operation asynchronous reset
    pb.alloc_req = 1;
    cyc();
    cyc();
    #2 reset = 1'b1;
    #1;
    chk("async_cnt12", int'(pb.free_count), 12);
    chk("async_id", int'(pb.alloc_id), 0);
    chk("async_err", int'(pb.err_valid), 0);
    chk("async_cnt16", int'(pa.free_count), 16);
    pb.alloc_req = 0;
    cyc();
    reset = 1'b0;
    cyc();
    chk("post_rst_cnt12", int'(pb.free_count), 12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
